// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the shift-register sequencer.
// Holds the FSM state enum, default sizes and the length saturation helper.
package shift_seq_pkg;

    localparam int SEQ_WIDTH = 64;
    localparam int SEQ_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Clamp a requested shift length to the largest supported length.
    function automatic logic [SEQ_CNT_W-1:0] sat_len(
        input logic [SEQ_CNT_W-1:0] len,
        input logic [SEQ_CNT_W-1:0] lim
    );
        return (len > lim) ? lim : len;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_capture.sv
// shift_seq_capture: collects serial samples from the shift register output.
// Ports: clk, r_n (sync active-low reset), clr (sync clear), stb (shift strobe),
//        bit_in (serial sample), word (captured word, newest sample in MSB).
module shift_seq_capture
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             clr,
    input  logic             stb,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word
);

    logic             stb_d;
    logic [WIDTH-1:0] cap;

    // The datapath output is registered, so the bit produced by a shift
    // edge is only visible one cycle later: sample on the delayed strobe.
    always_ff @(posedge clk) begin
        if (!r_n) begin
            stb_d <= 1'b0;
            cap   <= '0;
        end else if (clr) begin
            stb_d <= 1'b0;
            cap   <= '0;
        end else begin
            stb_d <= stb;
            if (stb_d) begin
                cap <= {bit_in, cap[WIDTH-1:1]};
            end
        end
    end

    assign word = cap;

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer for a serial shift register with no hold mode.
// Ports: clk, r_n (sync active-low); cmd_valid/ready/dir/len/data command port;
//        sr_in/sr_sl/sr_r/sr_out shift register side; rsp_valid/ready/data/len
//        response port; busy. Optional macro SHIFT_SEQ_ABORT_EN adds abort and
//        rsp_aborted.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             sr_in,
    output logic             sr_sl,
    output logic             sr_r,
    input  logic             sr_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [CNT_W-1:0] rsp_len,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
    output logic             rsp_aborted,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(2 * WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic             dir_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_sat;
    logic [WIDTH-1:0] tx;
    logic             rsp_valid_q;
    logic             accept;
    logic             in_shift;
    logic             stop;

    assign len_sat  = sat_len(cmd_len, LEN_MAX);
    assign accept   = cmd_valid & cmd_ready;
    assign in_shift = (state == SHIFT);
    assign cnt_inc  = cnt + ONE;

`ifdef SHIFT_SEQ_ABORT_EN
    assign stop = (cnt_inc == len_q) | abort;
`else
    assign stop = (cnt_inc == len_q);
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (len_sat == '0) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: state_n = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!r_n) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            len_q       <= '0;
            cnt         <= '0;
            tx          <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            rsp_valid_q <= (state_n == RESP);
            if (accept) begin
                dir_q <= cmd_dir;
                len_q <= len_sat;
                cnt   <= '0;
                tx    <= cmd_data;
            end else if (in_shift) begin
                cnt <= cnt_inc;
                tx  <= {1'b0, tx[WIDTH-1:1]};
            end
        end
    end

`ifdef SHIFT_SEQ_ABORT_EN
    logic aborted_q;

    always_ff @(posedge clk) begin
        if (!r_n) begin
            aborted_q <= 1'b0;
        end else if (accept) begin
            aborted_q <= 1'b0;
        end else if (in_shift && abort) begin
            aborted_q <= 1'b1;
        end
    end

    assign rsp_aborted = aborted_q;
`endif

    // The register is held in reset except while shifting, since it
    // cannot hold its contents.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign sr_r      = ~in_shift;
    assign sr_in     = in_shift & tx[0];
    assign sr_sl     = dir_q & (in_shift | (state == DRAIN));
    assign rsp_valid = rsp_valid_q;
    assign rsp_len   = cnt;

    shift_seq_capture #(
        .WIDTH (WIDTH)
    ) u_cap (
        .clk    (clk),
        .r_n    (r_n),
        .clr    (accept),
        .stb    (in_shift),
        .bit_in (sr_out),
        .word   (rsp_data)
    );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: self-checking bench for shift_seq_ctrl.
// Models the 64-bit shift register with a registered serial output.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int W  = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          r_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_len = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          sr_in;
    logic          sr_sl;
    logic          sr_r;
    logic          sr_out;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic [CW-1:0] rsp_len;
    logic          busy;
`ifdef SHIFT_SEQ_ABORT_EN
    logic          abort = 1'b0;
    logic          rsp_aborted;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] len;
        logic          ab;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    always #5 clk = ~clk;

    shift_seq_ctrl dut (
        .clk       (clk),
        .r_n       (r_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .sr_in     (sr_in),
        .sr_sl     (sr_sl),
        .sr_r      (sr_r),
        .sr_out    (sr_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_len   (rsp_len),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort       (abort),
        .rsp_aborted (rsp_aborted),
`endif
        .busy      (busy)
    );

    // Shift register datapath: always shifts unless reset, output registered.
    logic [W-1:0] q = '0;
    logic         out_q = 1'b0;

    always @(posedge clk) begin
        if (sr_r) begin
            q     <= '0;
            out_q <= 1'b0;
        end else if (sr_sl) begin
            out_q <= q[W-1];
            q     <= {q[W-2:0], sr_in};
        end else begin
            out_q <= q[0];
            q     <= {sr_in, q[W-1:1]};
        end
    end

    assign sr_out = out_q;

    // Bit sent in shift cycle k reaches the capture in sample k+64.
    function automatic logic [W-1:0] exp_cap(input logic [W-1:0] d, input int n);
        logic [W-1:0] c;
        logic         s;
        int           k;
        c = '0;
        for (int j = 1; j <= n; j++) begin
            k = j - 64;
            s = 1'b0;
            if (k >= 1 && k <= 64) s = d[k-1];
            c = {s, c[W-1:1]};
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (r_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got rsp_len=%0d expected no response", rsp_len);
            end else begin
                me = sb.pop_front();
`ifdef SHIFT_SEQ_ABORT_EN
                if (rsp_data !== me.data || rsp_len !== me.len || rsp_aborted !== me.ab) begin
`else
                if (rsp_data !== me.data || rsp_len !== me.len) begin
`endif
                    errors++;
                    $display("FAIL sb_rsp got data=%h len=%0d expected data=%h len=%0d",
                             rsp_data, rsp_len, me.data, me.len);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic dir, input int len, input logic [W-1:0] d,
                        input bit push);
        int   n;
        exp_t e;
        n = (len > 2 * W) ? 2 * W : len;
        e.data = exp_cap(d, n);
        e.len  = CW'(n);
        e.ab   = 1'b0;
        if (push) sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = CW'(len);
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int cyc);
        cyc = start;
        while (rsp_valid !== 1'b1 && cyc < start + 400) begin
            step();
            cyc++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        r_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({cmd_ready, busy, rsp_valid, sr_r, sr_sl, sr_in} !== 6'b100100) begin
            errors++;
            $display("FAIL reset_ctl got %b expected 100100",
                     {cmd_ready, busy, rsp_valid, sr_r, sr_sl, sr_in});
        end
        checks++;
        if (rsp_data !== '0 || rsp_len !== '0) begin
            errors++;
            $display("FAIL reset_rsp got data=%h len=%0d expected 0", rsp_data, rsp_len);
        end
        r_n = 1'b1;
        step();
    endtask

    task automatic test_len3();
        logic [2:0] pat;
        int         cyc;
        pat = 3'b101;
        send(1'b1, 3, 64'h5, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (sr_in !== pat[c-1] || sr_sl !== 1'b1 || sr_r !== 1'b0) begin
                errors++;
                $display("FAIL len3_shift c%0d got in=%b sl=%b r=%b expected %b 1 0",
                         c, sr_in, sr_sl, sr_r, pat[c-1]);
            end
            step();
        end
        checks++;
        if (sr_r !== 1'b1 || sr_in !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL len3_drain got r=%b in=%b v=%b expected 1 0 0",
                     sr_r, sr_in, rsp_valid);
        end
        step();
        wait_rsp(5, cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL len3_lat got %0d expected 5", cyc);
        end
        take_rsp();
        checks++;
        if (sr_sl !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL len3_idle got sl=%b rdy=%b expected 0 1", sr_sl, cmd_ready);
        end
    endtask

    task automatic test_loopback();
        int cyc;
        send(1'b1, 128, 64'hDEADBEEF01234567, 1'b1);
        wait_rsp(1, cyc);
        checks++;
        if (cyc != 130) begin
            errors++;
            $display("FAIL loop_lat got %0d expected 130", cyc);
        end
        checks++;
        if (rsp_data !== 64'hDEADBEEF01234567) begin
            errors++;
            $display("FAIL loop_data got %h expected deadbeef01234567", rsp_data);
        end
        take_rsp();
    endtask

    task automatic test_len_edges();
        int cyc;
        send(1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_rsp(1, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL len0_lat got %0d expected 1", cyc);
        end
        take_rsp();
        send(1'b0, 200, 64'h0123456789ABCDEF, 1'b1);
        wait_rsp(1, cyc);
        checks++;
        if (cyc != 130) begin
            errors++;
            $display("FAIL len200_lat got %0d expected 130", cyc);
        end
        take_rsp();
    endtask

    task automatic test_backpressure();
        int           cyc;
        logic [W-1:0] ed;
        ed = exp_cap({W{1'b1}}, 70);
        send(1'b1, 70, {W{1'b1}}, 1'b1);
        wait_rsp(1, cyc);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_len !== 8'd70
                || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold i%0d got v=%b d=%h l=%0d rdy=%b expected 1 %h 70 0",
                         i, rsp_valid, rsp_data, rsp_len, cmd_ready, ed);
            end
            cmd_valid = i[0];
            cmd_len   = 8'd3;
            cmd_data  = 64'h1234;
            step();
        end
        cmd_valid = 1'b0;
        take_rsp();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        rsp_ready = 1'b1;
        send(1'b0, 90, 64'hA5C3_0F96_1E2D_3C4B, 1'b1);
        wait_rsp(1, cyc);
        checks++;
        if (cyc != 92) begin
            errors++;
            $display("FAIL b2b_lat_a got %0d expected 92", cyc);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b expected 1", cmd_ready);
        end
        send(1'b1, 1, 64'h1, 1'b1);
        wait_rsp(1, cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL b2b_lat_b got %0d expected 3", cyc);
        end
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int cyc;
        bit seen;
        send(1'b1, 40, 64'hFFFF_0000_FFFF_0000, 1'b0);
        repeat (10) step();
        r_n = 1'b0;
        step();
        checks++;
        if ({busy, sr_r, rsp_valid, cmd_ready, sr_sl} !== 5'b01010) begin
            errors++;
            $display("FAIL rst_shift got %b expected 01010",
                     {busy, sr_r, rsp_valid, cmd_ready, sr_sl});
        end
        r_n  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_norsp got rsp_valid=1 expected never");
        end
        send(1'b0, 2, 64'h3, 1'b0);
        wait_rsp(1, cyc);
        r_n = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_len !== '0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_resp got v=%b l=%0d rdy=%b expected 0 0 1",
                     rsp_valid, rsp_len, cmd_ready);
        end
        r_n = 1'b1;
        step();
    endtask

`ifdef SHIFT_SEQ_ABORT_EN
    task automatic test_abort();
        int   cyc;
        exp_t e;
        e.data = exp_cap(64'hCAFE, 20);
        e.len  = 8'd20;
        e.ab   = 1'b1;
        sb.push_back(e);
        send(1'b1, 100, 64'hCAFE, 1'b0);
        repeat (19) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || sr_r !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain got busy=%b r=%b v=%b expected 1 1 0",
                     busy, sr_r, rsp_valid);
        end
        step();
        wait_rsp(22, cyc);
        checks++;
        if (cyc != 22 || rsp_aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort_rsp got cyc=%0d ab=%b expected 22 1", cyc, rsp_aborted);
        end
        take_rsp();
    endtask
`endif

    initial begin
        test_reset();
        test_len3();
        test_loopback();
        test_len_edges();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef SHIFT_SEQ_ABORT_EN
        test_abort();
`endif
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
